alu_shift_unit: RTL and testbench

//  Multi-bit shift/rotate engine for the cpu6502 ALU datapath: the parametrised

---
 rtl/alu_shift_unit.sv | 133 +++++++++++++
 tb/tb_alu_shift_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_unit.sv
// Multi-bit shift/rotate engine for the ALU datapath: one 1-bit step per clock
// under a start/busy/done handshake, with the result and N/Z/C flags held between operations.
module alu_shift_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             cin,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             nflag,
    output logic             zflag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ASL = 2'b00,
        OP_LSR = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    state_t           state;
    state_t           state_next;
    op_t              op_q;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] step_sr;
    logic             step_c;
    logic             accept;
    logic             finish;

    // A new request is honoured from IDLE and from DONE, so back-to-back ops need no bubble.
    assign accept = start && (state != S_SHIFT);
    assign finish = (state == S_SHIFT) && (rem == '0);
    assign busy   = (state == S_SHIFT);
    assign done   = (state == S_DONE);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (accept) state_next = S_SHIFT;
            S_SHIFT: if (finish) state_next = S_DONE;
            S_DONE:  state_next = accept ? S_SHIFT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ROL/ROR rotate through the carry, so the ring is WIDTH+1 bits long.
    always_comb begin
        step_sr = sr;
        step_c  = c;
        unique case (op_q)
            OP_ASL: begin
                step_c  = sr[WIDTH-1];
                step_sr = {sr[WIDTH-2:0], 1'b0};
            end
            OP_LSR: begin
                step_c  = sr[0];
                step_sr = {1'b0, sr[WIDTH-1:1]};
            end
            OP_ROL: begin
                step_c  = sr[WIDTH-1];
                step_sr = {sr[WIDTH-2:0], c};
            end
            OP_ROR: begin
                step_c  = sr[0];
                step_sr = {c, sr[WIDTH-1:1]};
            end
            default: begin
                step_c  = c;
                step_sr = sr;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= OP_ASL;
            sr   <= '0;
            c    <= 1'b0;
            rem  <= '0;
        end else if (accept) begin
            op_q <= op_t'(op);
            sr   <= din;
            c    <= cin;
            rem  <= count;
        end else if (busy && (rem != '0)) begin
            sr   <= step_sr;
            c    <= step_c;
            rem  <= rem - 1'b1;
        end
    end

    // Result and flags move only on entry to DONE; the flag/bus logic sees them stable otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            cout  <= 1'b0;
            nflag <= 1'b0;
            zflag <= 1'b0;
        end else if (finish) begin
            dout  <= sr;
            cout  <= c;
            nflag <= sr[WIDTH-1];
            zflag <= (sr == '0);
        end
    end

endmodule

// File: tb/tb_alu_shift_unit.sv
// Directed bench for alu_shift_unit: an 8-bit instance for the main scenarios
// and a 16-bit instance for the wide-operand cases.
module tb_alu_shift_unit;

    localparam logic [1:0] ASL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ROL = 2'b10;
    localparam logic [1:0] ROR = 2'b11;
    localparam int         LIMIT = 64;

    logic        clk;
    logic        reset;

    logic        start;
    logic [1:0]  op;
    logic [7:0]  din;
    logic        cin;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic [7:0]  dout;
    logic        cout;
    logic        nflag;
    logic        zflag;

    logic        w_start;
    logic [1:0]  w_op;
    logic [15:0] w_din;
    logic        w_cin;
    logic [4:0]  w_count;
    logic        w_busy;
    logic        w_done;
    logic [15:0] w_dout;
    logic        w_cout;
    logic        w_nflag;
    logic        w_zflag;

    int total;
    int bad;

    alu_shift_unit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .din(din), .cin(cin),
        .count(count), .busy(busy), .done(done), .dout(dout), .cout(cout),
        .nflag(nflag), .zflag(zflag)
    );

    alu_shift_unit #(.WIDTH(16), .CNT_W(5)) dut_wide (
        .clk(clk), .reset(reset), .start(w_start), .op(w_op), .din(w_din), .cin(w_cin),
        .count(w_count), .busy(w_busy), .done(w_done), .dout(w_dout), .cout(w_cout),
        .nflag(w_nflag), .zflag(w_zflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [7:0] d, input logic ci, input logic [3:0] n);
        op = o; din = d; cin = ci; count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen; an expired bound shows up as a latency failure.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; op = ROR; din = 8'hFF; cin = 1'b1; count = 4'd3;
        w_start = 1'b0; w_op = ASL; w_din = '0; w_cin = 1'b0; w_count = '0;
        #12;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_handshake got=%b want=00", {busy, done}); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", dout); end
        total++; if ({cout, nflag, zflag} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {cout, nflag, zflag}); end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_ror;
        int n;
        launch(ROR, 8'hFF, 1'b0, 4'd4);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b want=1", busy); end
        wait_done(n);
        total++; if (n !== 5) begin bad++; $display("FAIL t1_latency got=%0d want=5", n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_busy_at_done got=%b want=0", busy); end
        total++; if (dout !== 8'hEF) begin bad++; $display("FAIL t1_dout got=%h want=ef", dout); end
        total++; if ({cout, nflag, zflag} !== 3'b110) begin bad++; $display("FAIL t1_flags got=%b want=110", {cout, nflag, zflag}); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got=%b want=0", done); end
        total++; if (dout !== 8'hEF) begin bad++; $display("FAIL t1_hold got=%h want=ef", dout); end
    endtask

    task automatic test_asl_lsr;
        int n;
        launch(ASL, 8'h81, 1'b0, 4'd1);
        total++; if (dout !== 8'hEF) begin bad++; $display("FAIL t2_hold_busy got=%h want=ef", dout); end
        wait_done(n);
        total++; if (dout !== 8'h02) begin bad++; $display("FAIL t2_asl_dout got=%h want=02", dout); end
        total++; if ({cout, nflag} !== 2'b10) begin bad++; $display("FAIL t2_asl_cn got=%b want=10", {cout, nflag}); end
        @(negedge clk);
        launch(LSR, 8'h01, 1'b0, 4'd1);
        wait_done(n);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL t2_lsr_dout got=%h want=00", dout); end
        total++; if ({cout, zflag} !== 2'b11) begin bad++; $display("FAIL t2_lsr_cz got=%b want=11", {cout, zflag}); end
        @(negedge clk);
    endtask

    task automatic test_rotate_wrap;
        int n;
        launch(ROL, 8'hA5, 1'b1, 4'd9);
        wait_done(n);
        total++; if ({cout, dout} !== 9'h1A5) begin bad++; $display("FAIL t3_rol_wrap got=%h want=1a5", {cout, dout}); end
        @(negedge clk);
        launch(LSR, 8'h3C, 1'b1, 4'd0);
        wait_done(n);
        total++; if (n !== 1) begin bad++; $display("FAIL t3_pass_latency got=%0d want=1", n); end
        total++; if ({cout, dout} !== 9'h13C) begin bad++; $display("FAIL t3_pass_value got=%h want=13c", {cout, dout}); end
        @(negedge clk);
        launch(ASL, 8'hFF, 1'b0, 4'd8);
        wait_done(n);
        total++; if ({cout, zflag, dout} !== 10'h300) begin bad++; $display("FAIL t3_asl_full got=%h want=300", {cout, zflag, dout}); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        launch(ROR, 8'h01, 1'b0, 4'd7);
        @(negedge clk);
        op = ASL; din = 8'hFF; cin = 1'b1; count = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        total++; if ({cout, dout} !== 9'h004) begin bad++; $display("FAIL t4_ignored_start got=%h want=004", {cout, dout}); end
        launch(LSR, 8'hF0, 1'b0, 4'd4);
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL t4_no_bubble got=%b want=10", {busy, done}); end
        wait_done(n);
        total++; if (n !== 5) begin bad++; $display("FAIL t4_b2b_latency got=%0d want=5", n); end
        total++; if ({cout, dout} !== 9'h00F) begin bad++; $display("FAIL t4_b2b_value got=%h want=00f", {cout, dout}); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int n;
        int seen;
        launch(ASL, 8'h0F, 1'b0, 4'd6);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL t5_abort_handshake got=%b want=00", {busy, done}); end
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL t5_abort_dout got=%h want=00", dout); end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL t5_no_done got=%0d want=0", seen); end
        launch(ASL, 8'h03, 1'b0, 4'd2);
        wait_done(n);
        total++; if (n !== 3) begin bad++; $display("FAIL t5_next_latency got=%0d want=3", n); end
        total++; if ({cout, dout} !== 9'h00C) begin bad++; $display("FAIL t5_next_value got=%h want=00c", {cout, dout}); end
        @(negedge clk);
    endtask

    task automatic test_wide;
        int n;
        w_op = LSR; w_din = 16'h8000; w_cin = 1'b0; w_count = 5'd15; w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        n = 0;
        while (w_done !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        total++; if (n !== 16) begin bad++; $display("FAIL t6_lsr_latency got=%0d want=16", n); end
        total++; if ({w_cout, w_dout} !== 17'h00001) begin bad++; $display("FAIL t6_lsr_value got=%h want=00001", {w_cout, w_dout}); end
        @(negedge clk);
        w_op = ASL; w_din = 16'hFFFF; w_cin = 1'b1; w_count = 5'd20; w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        n = 0;
        while (w_done !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        total++; if (w_dout !== 16'h0000) begin bad++; $display("FAIL t6_asl_dout got=%h want=0000", w_dout); end
        total++; if ({w_cout, w_nflag, w_zflag} !== 3'b001) begin bad++; $display("FAIL t6_asl_flags got=%b want=001", {w_cout, w_nflag, w_zflag}); end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_ror;
        test_asl_lsr;
        test_rotate_wrap;
        test_back_to_back;
        test_reset_abort;
        test_wide;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
